// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and constants for the HI/LO register block
// Contents: hilo_state_t (ST_IDLE, ST_BUSY), default watchdog timeout and
// counter width, reset values for HI and LO.
package hilo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hilo_state_t;

  localparam int HILO_TIMEOUT = 40;
  localparam int HILO_CNT_W   = 6;

  localparam logic [31:0] HILO_RST_HI = 32'h0000_0000;
  localparam logic [31:0] HILO_RST_LO = 32'h0000_0000;

endpackage

// File: rtl/hilo_if.sv
// rtl/hilo_if.sv - request/response bundle between execute stage and hilo_ctrl
// master: drives md_start, md_done, md_dz, md_hi, md_lo, mthi, mtlo, wdata,
//         mfhi, mflo; observes rdata, hi, lo, stall, busy, dz_err, to_err.
// slave:  the opposite directions (used by hilo_ctrl).
interface hilo_if;

  logic        md_start;
  logic        md_done;
  logic        md_dz;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mfhi;
  logic        mflo;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        busy;
  logic        dz_err;
  logic        to_err;

  modport master (
    output md_start, md_done, md_dz, md_hi, md_lo,
    output mthi, mtlo, wdata, mfhi, mflo,
    input  rdata, hi, lo, stall, busy, dz_err, to_err
  );

  modport slave (
    input  md_start, md_done, md_dz, md_hi, md_lo,
    input  mthi, mtlo, wdata, mfhi, mflo,
    output rdata, hi, lo, stall, busy, dz_err, to_err
  );

endinterface

// File: rtl/hilo_watchdog.sv
// rtl/hilo_watchdog.sv - clear/enable cycle counter with expiry flag
// Ports: clk, rst (sync active-high), clr (hold count at 0), en (count this
// cycle), expire (enabled and count has reached TIMEOUT-1).
module hilo_watchdog #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register pair with mul/div issue interlock
// Ports: clk, rst (sync active-high), bus (hilo_if.slave): mul/div handshake
// md_start/md_done/md_dz/md_hi/md_lo, moves mthi/mtlo/wdata, reads
// mfhi/mflo/rdata, status hi/lo/stall/busy/dz_err/to_err.
// Optional: HILO_BYPASS_EN forwards md_hi/md_lo to mfhi/mflo in the done cycle.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int TIMEOUT = HILO_TIMEOUT,
  parameter int CNT_W   = HILO_CNT_W
) (
  input  logic   clk,
  input  logic   rst,
  hilo_if.slave  bus
);

  hilo_state_t state, state_nxt;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, rdata_c;
  logic        dz_q, dz_d, to_q, to_d, stall_c, fwd, wd_expire;
  logic        rd_req, wr_req;

  assign rd_req = bus.mfhi | bus.mflo;
  assign wr_req = bus.mthi | bus.mtlo;

  hilo_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_IDLE),
    .en     (state == ST_BUSY),
    .expire (wd_expire)
  );

  always_comb begin
    state_nxt = state;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    to_d      = to_q;
    stall_c   = 1'b0;
    fwd       = 1'b0;
    rdata_c   = 32'h0;
    case (state)
      ST_IDLE: begin
        // md_start outranks moves, moves outrank reads; losers are stalled.
        if (bus.md_start) begin
          state_nxt = ST_BUSY;
          stall_c   = wr_req | rd_req;
        end else if (wr_req) begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
          stall_c = rd_req;
        end
      end
      ST_BUSY: begin
`ifdef HILO_BYPASS_EN
        fwd = bus.md_done & ~bus.md_dz;
`endif
        stall_c = bus.md_start | wr_req | (rd_req & ~fwd);
        if (bus.md_done) begin
          state_nxt = ST_IDLE;
          if (bus.md_dz) begin
            dz_d = 1'b1;
          end else begin
            hi_d = bus.md_hi;
            lo_d = bus.md_lo;
          end
        end else if (wd_expire) begin
          state_nxt = ST_IDLE;
          to_d      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (bus.mfhi) begin
      rdata_c = fwd ? bus.md_hi : hi_q;
    end else if (bus.mflo) begin
      rdata_c = fwd ? bus.md_lo : lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hi_q  <= HILO_RST_HI;
      lo_q  <= HILO_RST_LO;
      dz_q  <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dz_q  <= dz_d;
      to_q  <= to_d;
    end
  end

  assign bus.rdata  = rdata_c;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.stall  = stall_c;
  assign bus.busy   = (state == ST_BUSY);
  assign bus.dz_err = dz_q;
  assign bus.to_err = to_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - self-checking bench for hilo_ctrl
module tb_hilo_ctrl;

  localparam int TO = 40;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  hilo_if bus ();

  hilo_ctrl #(.TIMEOUT(TO), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: one outstanding mul/div op with its age in cycles.
  logic [31:0] m_hi, m_lo, n_hi, n_lo, e_rdata;
  logic        m_pend, n_pend, m_dz, n_dz, m_to, n_to, e_stall, byp, armed;
  int          m_age, n_age;

  always_comb begin
    logic rd, wr;
    rd  = bus.mfhi || bus.mflo;
    wr  = bus.mthi || bus.mtlo;
    byp = 1'b0;
`ifdef HILO_BYPASS_EN
    byp = m_pend && bus.md_done && !bus.md_dz;
`endif
    if (m_pend) e_stall = bus.md_start || wr || (rd && !byp);
    else        e_stall = (bus.md_start && (wr || rd)) || (wr && rd);
    if (bus.mfhi)      e_rdata = byp ? bus.md_hi : m_hi;
    else if (bus.mflo) e_rdata = byp ? bus.md_lo : m_lo;
    else               e_rdata = 32'h0;
    n_hi = m_hi; n_lo = m_lo; n_pend = m_pend; n_age = m_age; n_dz = m_dz; n_to = m_to;
    if (rst) begin
      n_hi = 0; n_lo = 0; n_pend = 0; n_age = 0; n_dz = 0; n_to = 0;
    end else if (m_pend) begin
      if (bus.md_done) begin
        n_pend = 0;
        if (bus.md_dz) n_dz = 1;
        else begin n_hi = bus.md_hi; n_lo = bus.md_lo; end
      end else if (m_age == TO - 1) begin
        n_pend = 0; n_to = 1;
      end else n_age = m_age + 1;
    end else if (bus.md_start) begin
      n_pend = 1; n_age = 0;
    end else begin
      if (bus.mthi) n_hi = bus.wdata;
      if (bus.mtlo) n_lo = bus.wdata;
    end
  end

  initial begin
    armed = 1'b0; m_hi = 0; m_lo = 0; m_pend = 0; m_age = 0; m_dz = 0; m_to = 0;
  end

  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    m_hi <= n_hi; m_lo <= n_lo; m_pend <= n_pend;
    m_age <= n_age; m_dz <= n_dz; m_to <= n_to;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_stall",  32'(bus.stall),  32'(e_stall));
      chk("m_rdata",  bus.rdata,       e_rdata);
      chk("m_hi",     bus.hi,          m_hi);
      chk("m_lo",     bus.lo,          m_lo);
      chk("m_busy",   32'(bus.busy),   32'(m_pend));
      chk("m_dz_err", 32'(bus.dz_err), 32'(m_dz));
      chk("m_to_err", 32'(bus.to_err), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic clr_in();
    bus.md_start = 0; bus.md_done = 0; bus.md_dz = 0; bus.md_hi = 0; bus.md_lo = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0; bus.mfhi = 0; bus.mflo = 0;
  endtask

  initial begin
    int  n;
    bit  ended;
    rst = 1'b1;
    clr_in();
    ticks(2);
    @(negedge clk);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    tick();
    rst = 1'b0;

    // mthi then mfhi
    bus.mthi = 1; bus.wdata = 32'h1234_5678;
    tick();
    bus.mthi = 0; bus.mfhi = 1;
    @(negedge clk);
    chk("mthi_mfhi", bus.rdata, 32'h1234_5678);
    chk("mthi_lo0", bus.lo, 32'h0);
    tick();
    bus.mfhi = 0;

    // multu, 33 cycles to done, mflo held from cycle 1
    bus.md_start = 1;
    tick();
    bus.md_start = 0; bus.mflo = 1;
    ticks(31);
    @(negedge clk);
    chk("mul_stall_wait", 32'(bus.stall), 32'h1);
    tick();
    bus.md_done = 1; bus.md_hi = 32'h0000_0001; bus.md_lo = 32'hFFFF_FFFE;
    @(negedge clk);
`ifdef HILO_BYPASS_EN
    chk("mul_byp_stall", 32'(bus.stall), 32'h0);
    chk("mul_byp_rdata", bus.rdata, 32'hFFFF_FFFE);
`else
    chk("mul_done_stall", 32'(bus.stall), 32'h1);
`endif
    tick();
    bus.md_done = 0;
    @(negedge clk);
    chk("mul_after_stall", 32'(bus.stall), 32'h0);
    chk("mul_after_rdata", bus.rdata, 32'hFFFF_FFFE);
    chk("mul_hi", bus.hi, 32'h1);
    tick();
    bus.mflo = 0;

    // divide by zero keeps hi/lo, sets dz_err
    bus.mthi = 1; bus.wdata = 32'hAAAA_0000;
    tick();
    bus.mthi = 0; bus.mtlo = 1; bus.wdata = 32'h0000_5555;
    tick();
    bus.mtlo = 0; bus.md_start = 1;
    tick();
    bus.md_start = 0;
    ticks(5);
    bus.md_done = 1; bus.md_dz = 1; bus.md_hi = 32'hFFFF_FFFF; bus.md_lo = 32'hFFFF_FFFF;
    tick();
    bus.md_done = 0; bus.md_dz = 0;
    @(negedge clk);
    chk("dz_hi", bus.hi, 32'hAAAA_0000);
    chk("dz_lo", bus.lo, 32'h0000_5555);
    chk("dz_flag", 32'(bus.dz_err), 32'h1);
    ticks(3);

    // watchdog: busy for exactly TO cycles
    bus.md_start = 1;
    tick();
    bus.md_start = 0;
    n = 0; ended = 0;
    for (int i = 0; i < 100 && !ended; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else ended = 1;
      tick();
    end
    chk("to_ended", 32'(ended), 32'h1);
    chk("to_busy_cycles", 32'(n), 32'd40);
    bus.md_done = 1; bus.md_lo = 32'h0000_1234;
    tick();
    bus.md_done = 0;
    @(negedge clk);
    chk("to_flag", 32'(bus.to_err), 32'h1);
    chk("to_late_done_lo", bus.lo, 32'h0000_5555);
    chk("dz_sticky", 32'(bus.dz_err), 32'h1);
    tick();

    // reset mid-BUSY drops the pending result
    bus.md_start = 1;
    tick();
    bus.md_start = 0;
    ticks(9);
    rst = 1;
    tick();
    rst = 0;
    ticks(9);
    bus.md_done = 1; bus.md_lo = 32'h0000_DEAD;
    tick();
    bus.md_done = 0;
    @(negedge clk);
    chk("rstmid_lo", bus.lo, 32'h0);
    chk("rstmid_busy", 32'(bus.busy), 32'h0);
    chk("rstmid_flags", {30'h0, bus.dz_err, bus.to_err}, 32'h0);
    tick();

    // md_start + mtlo together: mtlo held until after done
    bus.md_start = 1; bus.mtlo = 1; bus.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("start_mtlo_stall", 32'(bus.stall), 32'h1);
    tick();
    bus.md_start = 0;
    ticks(5);
    bus.md_done = 1; bus.md_hi = 32'h2222_2222; bus.md_lo = 32'h1111_1111;
    tick();
    bus.md_done = 0;
    @(negedge clk);
    chk("mtlo_release", 32'(bus.stall), 32'h0);
    tick();
    bus.mtlo = 0;
    @(negedge clk);
    chk("mtlo_final_lo", bus.lo, 32'hCAFE_F00D);
    chk("mtlo_final_hi", bus.hi, 32'h2222_2222);
    tick();

    // mthi+mtlo together, then mfhi+mflo together (mfhi wins)
    bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'h0BAD_BEEF;
    tick();
    bus.mthi = 0; bus.wdata = 32'h0000_600D;
    tick();
    bus.mtlo = 0; bus.mfhi = 1; bus.mflo = 1;
    @(negedge clk);
    chk("both_rd_hi_wins", bus.rdata, 32'h0BAD_BEEF);
    tick();
    bus.mflo = 0; bus.mthi = 1; bus.wdata = 32'h7777_7777;
    @(negedge clk);
    chk("wr_beats_rd", 32'(bus.stall), 32'h1);
    tick();
    clr_in();
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
